// File: rtl/ui_pkg.sv
// Shared UI definitions: debounce timing default, per-channel FSM states and
// the LED view-select encodings driven by the debounced switches.
package ui_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

  localparam logic [3:0] VIEW_STATUS         = 4'h0;
  localparam logic [3:0] VIEW_PC_CALIB       = 4'h1;
  localparam logic [3:0] VIEW_BD_ADDR_LO     = 4'h2;
  localparam logic [3:0] VIEW_BD_CMD_ADDR_HI = 4'h3;
  localparam logic [3:0] VIEW_BDST           = 4'h4;
  localparam logic [3:0] VIEW_LC_LO          = 4'h5;
  localparam logic [3:0] VIEW_LC_HI          = 4'h6;
  localparam logic [3:0] VIEW_PC_BOOT        = 4'h7;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: 2-flop synchronizer, hold counter, IDLE/COUNT FSM and
// registered level / edge-pulse outputs.
module debounce_bit
  import ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic sw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic          sync1, sync2;
  db_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          level_next, rise_next, fall_next;
  logic          accept;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= DB_IDLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // The count this edge would produce; reaching LIMIT accepts the new level
  // on the same edge, so a limit of 1 flips straight out of IDLE.
  assign cnt_inc = (state == DB_IDLE) ? ONE : cnt + ONE;
  assign accept  = (cnt_inc == LIMIT);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      DB_IDLE: begin
        if (sync2 != level) begin
          if (accept) begin
            level_next = sync2;
            rise_next  = sync2;
            fall_next  = ~sync2;
            cnt_next   = '0;
          end else begin
            state_next = DB_COUNT;
            cnt_next   = ONE;
          end
        end
      end
      DB_COUNT: begin
        if (sync2 == level) begin
          state_next = DB_IDLE;
          cnt_next   = '0;
        end else if (accept) begin
          level_next = sync2;
          rise_next  = sync2;
          fall_next  = ~sync2;
          state_next = DB_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = DB_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the board slide switches into the registered view-select bus,
// with per-bit rise/fall pulses and a combined change pulse.
module switch_debouncer
  import ui_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .sysclk (sysclk),
      .reset_n(reset_n),
      .sw_in  (sw_in[i]),
      .level  (switches[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  // Pulses are already registered per bit, so the OR stays a clean one-cycle pulse.
  assign sw_changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_switch_debouncer;

  localparam int WIDTH = 4;
  localparam int DC    = 8;

  logic             sysclk;
  logic             reset_n;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] switches;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  int checks = 0;
  int errors = 0;

  switch_debouncer #(
    .WIDTH(WIDTH),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .sw_in     (sw_in),
    .switches  (switches),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [WIDTH-1:0] sw_exp,
                         input logic [WIDTH-1:0] rise_exp, input logic [WIDTH-1:0] fall_exp,
                         input logic chg_exp);
    chk({tag, ".switches"}, switches, sw_exp);
    chk({tag, ".rise"}, sw_rise, rise_exp);
    chk({tag, ".fall"}, sw_fall, fall_exp);
    chk({tag, ".changed"}, {3'b000, sw_changed}, {3'b000, chg_exp});
  endtask

  initial begin
    // Inputs change 1 ns after a rising edge, so the next edge is E0 and the
    // accepted level appears after the tenth edge from here (E0 + 9).
    reset_n = 1'b0;
    sw_in   = 4'b1010;
    step(3);
    chk_all("rst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    reset_n = 1'b1;
    step(9);
    chk_all("rst_rel_e8", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("rst_rel_e9", 4'b1010, 4'b1010, 4'b0000, 1'b1);
    step(1);
    chk_all("rst_rel_after", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // Glitch on bit 0 for 5 cycles
    sw_in = 4'b1011;
    step(5);
    sw_in = 4'b1010;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk_all("glitch", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    end

    // Release all switches: falls on bits 3 and 1
    sw_in = 4'b0000;
    step(9);
    chk_all("fall_e8", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("fall_e9", 4'b0000, 4'b0000, 4'b1010, 1'b1);
    step(1);
    chk_all("fall_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Clean press on bit 1, held 20 cycles
    sw_in = 4'b0010;
    step(9);
    chk_all("press_e8", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("press_e9", 4'b0010, 4'b0010, 4'b0000, 1'b1);
    step(1);
    chk_all("press_after", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(9);

    // Bounce on bit 2: toggle every 3 cycles for 30 cycles
    for (int t = 0; t < 10; t++) begin
      sw_in[2] = (t % 2 == 0);
      for (int c = 0; c < 3; c++) begin
        step(1);
        chk_all("bounce", 4'b0010, 4'b0000, 4'b0000, 1'b0);
      end
    end
    sw_in[2] = 1'b1;
    step(9);
    chk_all("bounce_e8", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("bounce_e9", 4'b0110, 4'b0100, 4'b0000, 1'b1);
    step(1);
    chk_all("bounce_after", 4'b0110, 4'b0000, 4'b0000, 1'b0);

    // Reach 4'b1010, then flip every bit at once
    sw_in = 4'b1010;
    step(10);
    chk_all("pre_simul", 4'b1010, 4'b1000, 4'b0100, 1'b1);
    step(1);
    sw_in = 4'b0101;
    step(9);
    chk_all("simul_e8", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("simul_e9", 4'b0101, 4'b0101, 4'b1010, 1'b1);
    step(1);
    chk_all("simul_after", 4'b0101, 4'b0000, 4'b0000, 1'b0);

    // Reset mid-count: counter reaches 5 seven edges after the input change
    sw_in = 4'b1111;
    step(7);
    chk_all("midcnt_pre", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("midcnt_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(2);
    chk_all("midcnt_held", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    step(9);
    chk_all("restart_e8", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    step(1);
    chk_all("restart_e9", 4'b1111, 4'b1111, 4'b0000, 1'b1);
    step(1);
    chk_all("restart_after", 4'b1111, 4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
